// File: rtl/pdm_decimator.sv
// pdm_decimator: boxcar PDM-to-PCM decimator with a valid/ready sample output.
// Define PDM_DECIM_SIGNED_EN for samples offset by DECIM/2 (signed, silence reads 0).
module pdm_decimator #(
  parameter int unsigned DECIM = 128,
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             m_clk_i,
  input  logic             m_data_i,
  output logic [OUT_W-1:0] sample_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             overrun_o
);

  localparam int unsigned   CW   = $clog2(DECIM);
  localparam logic [CW-1:0] LAST = CW'(DECIM - 1);

  logic             r_sync1;
  logic             r_d_s;
  logic             r_mclk_q;
  logic [CW-1:0]    r_bit_cnt;
  logic [CW:0]      r_acc;
  logic [OUT_W-1:0] r_sample;
  logic             r_valid;
  logic             r_overrun;

  logic             w_rise;
  logic             w_done;
  logic             w_load;
  logic [CW:0]      w_sum;
  logic [OUT_W-1:0] w_sum_ext;
  logic [OUT_W-1:0] w_fmt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_sync1  <= 1'b0;
      r_d_s    <= 1'b0;
      r_mclk_q <= 1'b0;
    end else begin
      r_sync1  <= m_data_i;
      r_d_s    <= r_sync1;
      r_mclk_q <= m_clk_i;
    end
  end

  assign w_rise = m_clk_i & ~r_mclk_q;
  assign w_sum  = r_acc + {{CW{1'b0}}, r_d_s};
  assign w_done = w_rise & en_i & (r_bit_cnt == LAST);
  // A full window is accepted if the slot is free or being drained this cycle.
  assign w_load = w_done & (~r_valid | ready_i);

  always_comb begin
    w_sum_ext        = '0;
    w_sum_ext[CW:0]  = w_sum;
  end

`ifdef PDM_DECIM_SIGNED_EN
  assign w_fmt = w_sum_ext - OUT_W'(DECIM / 2);
`else
  assign w_fmt = w_sum_ext;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_bit_cnt <= '0;
      r_acc     <= '0;
    end else if (!en_i) begin
      r_bit_cnt <= '0;
      r_acc     <= '0;
    end else if (w_rise) begin
      if (w_done) begin
        r_bit_cnt <= '0;
        r_acc     <= '0;
      end else begin
        r_bit_cnt <= r_bit_cnt + CW'(1);
        r_acc     <= w_sum;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_sample  <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_load) begin
        r_sample <= w_fmt;
        r_valid  <= 1'b1;
      end else if (ready_i) begin
        r_valid  <= 1'b0;
      end
      if (w_done && !w_load) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign sample_o  = r_sample;
  assign valid_o   = r_valid;
  assign overrun_o = r_overrun;

endmodule
